// File: rtl/bsg_link_isdr_rx_buffer_if.sv
// Receive-buffer link bundle: the capture-side word stream, the core-side
// valid/yumi handshake and the credit/overflow status returned by the buffer.
interface bsg_link_isdr_rx_buffer_if #(
    parameter int width_p = 16
);
    logic               io_v_i;
    logic [width_p-1:0] io_data_i;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;
    logic               token_o;
    logic               overflow_o;

    modport master (
        output io_v_i, io_data_i, yumi_i,
        input  v_o, data_o, token_o, overflow_o
    );

    modport slave (
        input  io_v_i, io_data_i, yumi_i,
        output v_o, data_o, token_o, overflow_o
    );
endinterface

// File: rtl/bsg_link_isdr_rx_buffer.sv
// IO-domain elastic buffer behind the SDR capture flops. It queues captured
// words, hands them to the core with valid/yumi and returns decimated credits.
module bsg_link_isdr_rx_buffer #(
    parameter int width_p                = 16,
    parameter int lg_fifo_depth_p        = 3,
    parameter int lg_credit_decimation_p = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    bsg_link_isdr_rx_buffer_if.slave       link
);
    typedef logic [lg_fifo_depth_p-1:0] ptr_t;
    typedef logic [lg_fifo_depth_p:0]   cnt_t;

    localparam cnt_t depth_lp = cnt_t'(1) << lg_fifo_depth_p;
    localparam ptr_t ptr_one  = ptr_t'(1);
    localparam cnt_t cnt_one  = cnt_t'(1);

    logic [width_p-1:0] mem [2**lg_fifo_depth_p];
    ptr_t               wptr, rptr;
    cnt_t               count;
    logic               token_r, overflow_r;

    logic full, not_empty, deq, enq, drop;

    // A word arriving while full is still accepted if the head leaves in
    // the same cycle; otherwise it is discarded and flagged.
    always_comb begin
        full      = (count == depth_lp);
        not_empty = (count != '0);
        deq       = link.yumi_i & not_empty;
        enq       = link.io_v_i & (~full | deq);
        drop      = link.io_v_i & full & ~deq;
    end

    always_ff @(posedge clk_i) begin
        if (enq)
            mem[wptr] <= link.io_data_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (enq)
                wptr <= wptr + ptr_one;
            if (deq)
                rptr <= rptr + ptr_one;
            case ({enq, deq})
                2'b10:   count <= count + cnt_one;
                2'b01:   count <= count - cnt_one;
                default: count <= count;
            endcase
            if (drop)
                overflow_r <= 1'b1;
        end
    end

    generate
        if (lg_credit_decimation_p == 0) begin : g_no_decim
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i)
                    token_r <= 1'b0;
                else if (deq)
                    token_r <= ~token_r;
            end
        end else begin : g_decim
            typedef logic [lg_credit_decimation_p-1:0] cred_t;
            cred_t credit_cnt;

            // Counter wraps on its own; the toggle rides on the wrap.
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    credit_cnt <= '0;
                    token_r    <= 1'b0;
                end else if (deq) begin
                    credit_cnt <= credit_cnt + cred_t'(1);
                    if (&credit_cnt)
                        token_r <= ~token_r;
                end
            end
        end
    endgenerate

    assign link.v_o        = not_empty;
    assign link.data_o     = mem[rptr];
    assign link.token_o    = token_r;
    assign link.overflow_o = overflow_r;

    yumi_without_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) !(link.yumi_i && !not_empty)
    ) else $error("yumi_i asserted while v_o is low");
endmodule

// File: tb/tb_bsg_link_isdr_rx_buffer.sv
// Scoreboard bench: the driver models the buffer as a plain word queue and
// pushes expectations; a negedge monitor pops and compares against the DUT.
module tb_bsg_link_isdr_rx_buffer;
    localparam int W     = 16;
    localparam int DEPTH = 8;
    localparam int DECIM = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    bsg_link_isdr_rx_buffer_if #(.width_p(W)) lnk ();

    bsg_link_isdr_rx_buffer #(
        .width_p(W), .lg_fifo_depth_p(3), .lg_credit_decimation_p(2)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .link(lnk)
    );

    typedef struct packed {
        logic         v;
        logic [W-1:0] head;
        logic         tok;
        logic         ovf;
    } stat_t;

    stat_t        stat_q[$];
    logic [W-1:0] data_q[$];

    // Reference model state
    logic [W-1:0] m_q[$];
    int           m_deqs;
    logic         m_tok, m_ovf;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus. Inputs change 1 time unit after the posedge.
    task automatic cyc(input bit rstn, input bit v, input logic [W-1:0] d, input bit y);
        bit    vv, yy;
        int    sz;
        stat_t s;
        vv = rstn && v;
        yy = rstn && y && (m_q.size() != 0);
        reset_n       = rstn;
        lnk.io_v_i    = vv;
        lnk.io_data_i = d;
        lnk.yumi_i    = yy;
        if (!rstn) begin
            m_q.delete();
            m_deqs = 0;
            m_tok  = 1'b0;
            m_ovf  = 1'b0;
        end
        s.v    = (m_q.size() != 0);
        s.head = s.v ? m_q[0] : '0;
        s.tok  = m_tok;
        s.ovf  = m_ovf;
        stat_q.push_back(s);
        sz = m_q.size();
        if (yy) begin
            data_q.push_back(m_q.pop_front());
            m_deqs++;
            if (m_deqs % DECIM == 0)
                m_tok = ~m_tok;
        end
        if (vv) begin
            if (sz < DEPTH || yy)
                m_q.push_back(d);
            else
                m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare status every cycle, data on each dequeue.
    initial begin
        stat_t s;
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (stat_q.size() != 0) begin
                s = stat_q.pop_front();
                chk("v_o", W'(lnk.v_o), W'(s.v));
                chk("token_o", W'(lnk.token_o), W'(s.tok));
                chk("overflow_o", W'(lnk.overflow_o), W'(s.ovf));
                if (s.v)
                    chk("head_data", lnk.data_o, s.head);
            end
            if (lnk.yumi_i && lnk.v_o) begin
                if (data_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL deq_data: dequeue with no expected word at %0t", $time);
                end else begin
                    e = data_q.pop_front();
                    chk("deq_data", lnk.data_o, e);
                end
            end
        end
    end

    initial begin
        reset_n       = 1'b0;
        lnk.io_v_i    = 1'b0;
        lnk.io_data_i = '0;
        lnk.yumi_i    = 1'b0;
        m_deqs = 0;
        m_tok  = 1'b0;
        m_ovf  = 1'b0;
        @(posedge clk);
        #1;

        // Reset state and first-word latency
        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 16'h00A5, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);

        // Order and fill
        for (int i = 1; i <= 8; i++) cyc(1, 1, W'(i), 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);

        // Overflow while full
        for (int i = 1; i <= 8; i++) cyc(1, 1, W'(i), 0);
        cyc(1, 1, 16'hDEAD, 0);
        repeat (2) cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1);
        repeat (2) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // Full with simultaneous enqueue and dequeue
        for (int i = 1; i <= 8; i++) cyc(1, 1, W'(i), 0);
        cyc(1, 1, 16'h0009, 1);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // Credit stream: 12 words through, then 3 more dequeues
        for (int i = 0; i < 13; i++) cyc(1, i < 12, W'(16'h0100 + i), 1);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, W'(16'h0200 + i), 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);
        repeat (2) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // Reset with 5 buffered and a partial credit group of 3
        for (int i = 0; i < 8; i++) cyc(1, 1, W'(16'h0300 + i), 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, W'(16'h0400 + i), 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);
        repeat (2) cyc(1, 0, 0, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0)
                cyc(0, 0, 0, 0);
            else
                cyc(1, $urandom_range(99) < 60, W'($urandom), $urandom_range(99) < 50);
        end
        repeat (10) cyc(1, 0, 0, 1);

        @(negedge clk);
        @(negedge clk);
        total++;
        if (data_q.size() != 0 || stat_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d data and %0d status expectations left, want 0",
                     data_q.size(), stat_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
